// File: rtl/pipelined_control_unit_if.sv
// ID/EX control-bundle interface for pipelined_control_unit.
// The master drives the ID-stage fields and flush. The slave (the control
// unit) drives the stall, the registered EX bundle and the status outputs.
interface pipelined_control_unit_if #(
  parameter int OPCODE_W    = 6,
  parameter int REG_ADDR_W  = 5,
  parameter int ALU_OP_W    = 2,
  parameter int STALL_CNT_W = 16
);
  logic                   id_valid;
  logic [OPCODE_W-1:0]    id_opcode;
  logic [REG_ADDR_W-1:0]  id_rs;
  logic [REG_ADDR_W-1:0]  id_rt;
  logic [REG_ADDR_W-1:0]  id_rd;
  logic                   flush;
  logic                   stall;
  logic                   ex_valid;
  logic                   ex_reg_dst;
  logic                   ex_branch;
  logic                   ex_branch_ne;
  logic                   ex_jump;
  logic                   ex_mem_read;
  logic                   ex_mem_to_reg;
  logic                   ex_mem_write;
  logic                   ex_alu_src;
  logic                   ex_reg_write;
  logic [ALU_OP_W-1:0]    ex_alu_op;
  logic [REG_ADDR_W-1:0]  ex_wr_addr;
  logic                   illegal_op;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd, flush,
    input  stall, ex_valid, ex_reg_dst, ex_branch, ex_branch_ne, ex_jump,
           ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write,
           ex_alu_op, ex_wr_addr, illegal_op, stall_count
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd, flush,
    output stall, ex_valid, ex_reg_dst, ex_branch, ex_branch_ne, ex_jump,
           ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write,
           ex_alu_op, ex_wr_addr, illegal_op, stall_count
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// Decode-stage control unit with a registered ID/EX control bundle.
// It detects load-use hazards, inserts bubbles on flush and illegal
// opcodes, and keeps a sticky illegal flag and a saturating stall counter.
// Optional feature macro: CTRL_HAZARD_DETECT_EN (load-use stall detection).
// When the macro is undefined, stall is constant 0.
module pipelined_control_unit #(
  parameter int OPCODE_W    = 6,
  parameter int REG_ADDR_W  = 5,
  parameter int ALU_OP_W    = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  pipelined_control_unit_if.slave bus
);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6);

  logic                  w_reg_dst;
  logic                  w_branch;
  logic                  w_branch_ne;
  logic                  w_jump;
  logic                  w_mem_read;
  logic                  w_mem_to_reg;
  logic                  w_mem_write;
  logic                  w_alu_src;
  logic                  w_reg_write;
  logic [ALU_OP_W-1:0]   w_alu_op;
  logic                  w_uses_rt;
  logic                  w_illegal;
  logic                  w_hazard;
  logic                  w_stall;
  logic                  w_load;
  logic [REG_ADDR_W-1:0] r_ex_rt;

  // Decode the ID opcode into datapath controls.
  always_comb begin
    w_reg_dst    = 1'b0;
    w_branch     = 1'b0;
    w_branch_ne  = 1'b0;
    w_jump       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_to_reg = 1'b0;
    w_mem_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_op     = '0;
    w_uses_rt    = 1'b0;
    w_illegal    = 1'b0;
    case (bus.id_opcode)
      OP_RTYPE: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
        w_alu_op    = ALU_OP_W'(2'b10);
        w_uses_rt   = 1'b1;
      end
      OP_LW: begin
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_alu_src    = 1'b1;
        w_reg_write  = 1'b1;
      end
      OP_SW: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_uses_rt   = 1'b1;
      end
      OP_BEQ: begin
        w_branch  = 1'b1;
        w_alu_op  = ALU_OP_W'(2'b01);
        w_uses_rt = 1'b1;
      end
      OP_ADDI: begin
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      OP_BNE: begin
        w_branch    = 1'b1;
        w_branch_ne = 1'b1;
        w_alu_op    = ALU_OP_W'(2'b01);
        w_uses_rt   = 1'b1;
      end
      OP_J: begin
        w_jump = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

`ifdef CTRL_HAZARD_DETECT_EN
  // Load-use hazard: the load in EX writes a register that the ID instruction reads.
  assign w_hazard = bus.id_valid & bus.ex_valid & bus.ex_mem_read &
                    (r_ex_rt != '0) &
                    ((r_ex_rt == bus.id_rs) | (w_uses_rt & (r_ex_rt == bus.id_rt)));
`else
  // Detection is disabled. The operands are still referenced so that the
  // captured rt stays a read signal, but the value is constant 0.
  assign w_hazard = 1'b0 & (|{r_ex_rt, bus.id_rs, bus.id_rt, w_uses_rt});
`endif

  assign w_stall   = w_hazard & ~bus.flush;
  assign bus.stall = w_stall;

  // Reset, flush, stall, an illegal opcode and an idle ID stage all load the
  // same all-zero bubble, so they collapse into one "not a load" condition.
  assign w_load = bus.id_valid & ~bus.flush & ~w_stall & ~w_illegal;

  // Register the ID/EX control bundle.
  always_ff @(posedge clk) begin
    if (reset || !w_load) begin
      bus.ex_valid      <= 1'b0;
      bus.ex_reg_dst    <= 1'b0;
      bus.ex_branch     <= 1'b0;
      bus.ex_branch_ne  <= 1'b0;
      bus.ex_jump       <= 1'b0;
      bus.ex_mem_read   <= 1'b0;
      bus.ex_mem_to_reg <= 1'b0;
      bus.ex_mem_write  <= 1'b0;
      bus.ex_alu_src    <= 1'b0;
      bus.ex_reg_write  <= 1'b0;
      bus.ex_alu_op     <= '0;
      bus.ex_wr_addr    <= '0;
      r_ex_rt           <= '0;
    end else begin
      bus.ex_valid      <= 1'b1;
      bus.ex_reg_dst    <= w_reg_dst;
      bus.ex_branch     <= w_branch;
      bus.ex_branch_ne  <= w_branch_ne;
      bus.ex_jump       <= w_jump;
      bus.ex_mem_read   <= w_mem_read;
      bus.ex_mem_to_reg <= w_mem_to_reg;
      bus.ex_mem_write  <= w_mem_write;
      bus.ex_alu_src    <= w_alu_src;
      bus.ex_reg_write  <= w_reg_write;
      bus.ex_alu_op     <= w_alu_op;
      bus.ex_wr_addr    <= w_reg_dst ? bus.id_rd : bus.id_rt;
      r_ex_rt           <= bus.id_rt;
    end
  end

  // Sticky illegal-opcode flag, set only when the bad opcode is actually consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.illegal_op <= 1'b0;
    end else if (bus.id_valid && w_illegal && !bus.flush && !w_stall) begin
      bus.illegal_op <= 1'b1;
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.stall_count <= '0;
    end else if (w_stall && (bus.stall_count != '1)) begin
      bus.stall_count <= bus.stall_count + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench for pipelined_control_unit. Each step drives one ID
// instruction, checks the combinational stall, and pushes the expected EX
// bundle, illegal flag and stall count. These are popped and compared
// after the next edge. The expectations follow CTRL_HAZARD_DETECT_EN.
module tb_pipelined_control_unit;

  localparam int OW = 6;
  localparam int RW = 5;
  localparam int AW = 2;
  localparam int CW = 2;

`ifdef CTRL_HAZARD_DETECT_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic clk;
  logic reset;

  pipelined_control_unit_if #(
    .OPCODE_W(OW), .REG_ADDR_W(RW), .ALU_OP_W(AW), .STALL_CNT_W(CW)
  ) bus ();

  pipelined_control_unit #(
    .OPCODE_W(OW), .REG_ADDR_W(RW), .ALU_OP_W(AW), .STALL_CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0]   ex;
    logic          ill;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  logic          m_ev;
  logic          m_mr;
  logic [RW-1:0] m_rt;
  logic          m_ill;
  logic [CW-1:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode table: {reg_dst,branch,branch_ne,jump,mem_read,mem_to_reg,mem_write,alu_src,reg_write,alu_op}
  function automatic logic [10:0] ref_dec(input logic [OW-1:0] op);
    case (op)
      6'd0:    return 11'b1_0_0_0_0_0_0_0_1_10;
      6'd1:    return 11'b0_0_0_0_1_1_0_1_1_00;
      6'd2:    return 11'b0_0_0_0_0_0_1_1_0_00;
      6'd3:    return 11'b0_1_0_0_0_0_0_0_0_01;
      6'd4:    return 11'b0_0_0_0_0_0_0_1_1_00;
      6'd5:    return 11'b0_1_1_0_0_0_0_0_0_01;
      6'd6:    return 11'b0_0_0_1_0_0_0_0_0_00;
      default: return 11'b0;
    endcase
  endfunction

  function automatic logic [16:0] dut_vec();
    return {bus.ex_valid, bus.ex_reg_dst, bus.ex_branch, bus.ex_branch_ne, bus.ex_jump,
            bus.ex_mem_read, bus.ex_mem_to_reg, bus.ex_mem_write, bus.ex_alu_src,
            bus.ex_reg_write, bus.ex_alu_op, bus.ex_wr_addr};
  endfunction

  task automatic step(input logic rst, input logic v, input logic [OW-1:0] op,
                      input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                      input logic [RW-1:0] rd, input logic fl);
    logic [10:0] d;
    logic        legal;
    logic        ur;
    logic        haz;
    logic        st;
    exp_t        e;
    exp_t        got;
    reset         = rst;
    bus.id_valid  = v;
    bus.id_opcode = op;
    bus.id_rs     = rs;
    bus.id_rt     = rt;
    bus.id_rd     = rd;
    bus.flush     = fl;
    #1;
    d     = ref_dec(op);
    legal = (op <= 6'd6);
    ur    = (op == 6'd0) || (op == 6'd2) || (op == 6'd3) || (op == 6'd5);
    haz   = HZ && v && m_ev && m_mr && (m_rt != '0) &&
            ((m_rt == rs) || (ur && (m_rt == rt)));
    st    = haz && !fl;
    check("stall", {31'd0, bus.stall}, {31'd0, st});
    if (rst) begin
      m_ev = 1'b0; m_mr = 1'b0; m_rt = '0; m_ill = 1'b0; m_cnt = '0;
      e.ex = '0;
    end else begin
      if (st && (m_cnt != '1)) m_cnt = m_cnt + 1'b1;
      if (v && !legal && !fl && !st) m_ill = 1'b1;
      if (fl || st || !v || !legal) begin
        e.ex = '0;
        m_ev = 1'b0; m_mr = 1'b0; m_rt = '0;
      end else begin
        e.ex = {1'b1, d, (d[10] ? rd : rt)};
        m_ev = 1'b1; m_mr = d[6]; m_rt = rt;
      end
    end
    e.ill = m_ill;
    e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("ex_bundle", {15'd0, dut_vec()}, {15'd0, got.ex});
    check("illegal_op", {31'd0, bus.illegal_op}, {31'd0, got.ill});
    check("stall_count", {30'd0, bus.stall_count}, {30'd0, got.cnt});
  endtask

  initial begin
    m_ev = 1'b0; m_mr = 1'b0; m_rt = '0; m_ill = 1'b0; m_cnt = '0;
    reset = 1'b1;
    bus.id_valid = 1'b0; bus.id_opcode = '0; bus.id_rs = '0;
    bus.id_rt = '0; bus.id_rd = '0; bus.flush = 1'b0;

    // Reset for two cycles.
    step(1, 0, 6'd0, 5'd0, 5'd0, 5'd0, 0);
    step(1, 0, 6'd0, 5'd0, 5'd0, 5'd0, 0);
    // RType with rd=3.
    step(0, 1, 6'd0, 5'd1, 5'd2, 5'd3, 0);
    // LW rt=5, then ADD rs=5. The ADD is held and re-presented.
    step(0, 1, 6'd1, 5'd1, 5'd5, 5'd0, 0);
    step(0, 1, 6'd0, 5'd5, 5'd6, 5'd7, 0);
    check("stall_after_first_hazard", {30'd0, bus.stall_count}, HZ ? 32'd1 : 32'd0);
    step(0, 1, 6'd0, 5'd5, 5'd6, 5'd7, 0);
    // LW rt=0, then ADD rs=0: no stall.
    step(0, 1, 6'd1, 5'd1, 5'd0, 5'd0, 0);
    step(0, 1, 6'd0, 5'd0, 5'd6, 5'd7, 0);
    // LW rt=5, then ADDI rs=2 rt=5: no stall, because ADDI does not read rt.
    step(0, 1, 6'd1, 5'd1, 5'd5, 5'd0, 0);
    step(0, 1, 6'd4, 5'd2, 5'd5, 5'd0, 0);
    // LW rt=5, then BNE rt=5 with flush: flush wins.
    step(0, 1, 6'd1, 5'd1, 5'd5, 5'd0, 0);
    step(0, 1, 6'd5, 5'd1, 5'd5, 5'd0, 1);
    step(0, 1, 6'd5, 5'd1, 5'd5, 5'd0, 0);
    // Illegal opcode, then the flag stays set through legal opcodes.
    step(0, 1, 6'h3F, 5'd1, 5'd2, 5'd3, 0);
    step(0, 1, 6'd2, 5'd1, 5'd2, 5'd3, 0);
    step(0, 1, 6'd6, 5'd1, 5'd2, 5'd3, 0);
    step(0, 1, 6'd3, 5'd1, 5'd2, 5'd3, 0);
    step(0, 0, 6'd0, 5'd1, 5'd2, 5'd3, 0);
    // Stall-count saturation with repeated load-use pairs.
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 6'd1, 5'd1, 5'd3, 5'd0, 0);
      step(0, 1, 6'd0, 5'd3, 5'd4, 5'd9, 0);
    end
    check("stall_count_sat", {30'd0, bus.stall_count}, HZ ? 32'd3 : 32'd0);
    // Reset during a hazard cycle.
    step(0, 1, 6'd1, 5'd1, 5'd4, 5'd0, 0);
    step(1, 1, 6'd0, 5'd4, 5'd1, 5'd2, 0);
    step(0, 1, 6'd0, 5'd4, 5'd1, 5'd2, 0);
    // Random traffic with small register numbers to provoke collisions.
    for (int i = 0; i < 80; i++) begin
      step(($urandom_range(0, 29) == 0),
           ($urandom_range(0, 7) != 0),
           OW'($urandom_range(0, 8)),
           RW'($urandom_range(0, 3)),
           RW'($urandom_range(0, 3)),
           RW'($urandom_range(0, 31)),
           ($urandom_range(0, 7) == 0));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
